// File: rtl/r_burst_buffer_if.sv
`timescale 1ns/1ps
// r_if: AXI R-channel bundle (id/data/resp/last with valid/ready handshake).
//   sender   : drives payload and valid, observes ready
//   receiver : observes payload and valid, drives ready
interface r_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2
);
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;
    logic                  valid;
    logic                  ready;

    modport sender   (output id, data, resp, last, valid, input ready);
    modport receiver (input id, data, resp, last, valid, output ready);
endinterface

// File: rtl/r_burst_buffer.sv
`timescale 1ns/1ps
// r_burst_buffer: parametrised R-beat buffer between the AXI slave R channel
// and r_ordering_unit. Optionally holds beats back until a complete burst
// (a beat with LAST) is stored, and reports occupancy, almost-full and a
// saturating count of error responses.
//
// Ports:
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   r_in          : R beats from the AXI slave (receiver side, drives ready)
//   r_out         : R beats to r_ordering_unit (sender side, drives valid/payload)
//   occupancy     : number of stored beats
//   almost_full   : occupancy >= AF_THRESH
//   bursts_stored : number of stored beats with last=1
//   err_cnt       : accepted beats with resp[1]=1, saturating at all-ones
module r_burst_buffer #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int DEPTH      = 16,
    parameter int STORE_FWD  = 1,
    parameter int AF_THRESH  = 14,
    parameter int ERR_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    r_if.receiver                        r_in,
    r_if.sender                          r_out,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   bursts_stored,
    output logic [ERR_W-1:0]             err_cnt
);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Entry layout: {id, data, resp, last}; last sits in bit 0.
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               full;
    logic               empty;
    logic               release_ok;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] out_entry;

    assign full  = (occupancy == DEPTH_C);
    assign empty = (occupancy == '0);

    // Ready depends only on stored state so no path exists from r_in.valid.
    assign r_in.ready = ~full;

    // In store-and-forward mode the head is released once any complete burst
    // is stored. The full term lets bursts longer than DEPTH drain cut-through
    // instead of deadlocking.
    assign release_ok  = (STORE_FWD == 0) || (bursts_stored != '0) || full;
    assign r_out.valid = ~empty & release_ok;

    assign push = r_in.valid & ~full;
    assign pop  = r_out.valid & r_out.ready;

    assign head      = mem[rd_ptr];
    assign out_entry = r_out.valid ? head : '0;

    assign r_out.id   = out_entry[ENTRY_W-1 -: ID_WIDTH];
    assign r_out.data = out_entry[DATA_WIDTH+RESP_WIDTH : RESP_WIDTH+1];
    assign r_out.resp = out_entry[RESP_WIDTH:1];
    assign r_out.last = out_entry[0];

    assign almost_full = (occupancy >= AF_C);

    // Storage array is not reset; only the pointers qualify its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {r_in.id, r_in.data, r_in.resp, r_in.last};
        end
    end

    // Pointers wrap by explicit compare so any DEPTH works, not only powers of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occupancy     <= '0;
            bursts_stored <= '0;
            err_cnt       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase

            case ({push & r_in.last, pop & head[0]})
                2'b10:   bursts_stored <= bursts_stored + 1'b1;
                2'b01:   bursts_stored <= bursts_stored - 1'b1;
                default: bursts_stored <= bursts_stored;
            endcase

            // SLVERR and DECERR both have resp[1] set; count saturates.
            if (push && r_in.resp[1] && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_r_burst_buffer.sv
`timescale 1ns/1ps
// tb_r_burst_buffer: scoreboard bench for r_burst_buffer. Two instances are
// exercised: a store-and-forward buffer (DEPTH=16, AF_THRESH=14, ERR_W=2) and
// a cut-through buffer with a non-power-of-2 depth (DEPTH=5).
module tb_r_burst_buffer;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks   = 0;
    int failures = 0;

    beat_t q_sf[$];
    beat_t q_ct[$];

    r_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2)) sf_in ();
    r_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2)) sf_out ();
    r_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2)) ct_in ();
    r_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2)) ct_out ();

    logic [4:0] sf_occ;
    logic [4:0] sf_bursts;
    logic       sf_af;
    logic [1:0] sf_err;
    logic [2:0] ct_occ;
    logic [2:0] ct_bursts;
    logic       ct_af;
    logic [7:0] ct_err;

    r_burst_buffer #(
        .ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2), .DEPTH(16),
        .STORE_FWD(1), .AF_THRESH(14), .ERR_W(2)
    ) u_sf (
        .clk(clk), .rst_n(rst_n), .r_in(sf_in), .r_out(sf_out),
        .occupancy(sf_occ), .almost_full(sf_af),
        .bursts_stored(sf_bursts), .err_cnt(sf_err)
    );

    r_burst_buffer #(
        .ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2), .DEPTH(5),
        .STORE_FWD(0), .AF_THRESH(4), .ERR_W(8)
    ) u_ct (
        .clk(clk), .rst_n(rst_n), .r_in(ct_in), .r_out(ct_out),
        .occupancy(ct_occ), .almost_full(ct_af),
        .bursts_stored(ct_bursts), .err_cnt(ct_err)
    );

    always #5 clk = ~clk;

    // Error-response table: resp per beat and the hand-computed err_cnt
    // (2-bit, saturating) after each beat is accepted.
    logic [1:0] resp_seq [10] = '{2'b10, 2'b00, 2'b10, 2'b01, 2'b10,
                                  2'b00, 2'b11, 2'b10, 2'b01, 2'b10};
    logic [1:0] err_exp  [10] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3,
                                  2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

    function automatic beat_t mkBeat(input logic [3:0] id, input logic [63:0] data,
                                     input logic [1:0] resp, input logic last);
        beat_t b;
        b.id   = id;
        b.data = data;
        b.resp = resp;
        b.last = last;
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Presents one beat (caller is just after a rising edge), waits for it
    // to be accepted, records the expectation, and returns just after the
    // accepting edge with valid still high.
    task automatic applyStimulus(input bit use_ct, input beat_t b);
        int waited;
        if (use_ct) begin
            ct_in.id = b.id; ct_in.data = b.data; ct_in.resp = b.resp;
            ct_in.last = b.last; ct_in.valid = 1'b1;
        end else begin
            sf_in.id = b.id; sf_in.data = b.data; sf_in.resp = b.resp;
            sf_in.last = b.last; sf_in.valid = 1'b1;
        end
        waited = 0;
        @(negedge clk);
        while (!(use_ct ? ct_in.ready : sf_in.ready) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            checkOutput("push_timeout", 128'(waited), 128'(0));
        end else if (use_ct) begin
            q_ct.push_back(b);
        end else begin
            q_sf.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleIn(input bit use_ct);
        if (use_ct) ct_in.valid = 1'b0;
        else        sf_in.valid = 1'b0;
    endtask

    task automatic waitDrain(input bit use_ct, input string name);
        int n;
        n = 0;
        while (((use_ct ? q_ct.size() : q_sf.size()) != 0 ||
                (use_ct ? 5'(ct_occ) : sf_occ) != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, use_ct ? 128'(ct_occ) : 128'(sf_occ), 128'(0));
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks the
    // structural invariants once per cycle, away from the rising edge.
    logic        sf_hold = 1'b0;
    logic [71:0] sf_prev = '0;

    always @(negedge clk) begin
        beat_t       act;
        beat_t       exp;
        logic [71:0] cur;
        if (!rst_n) begin
            sf_hold = 1'b0;
        end else begin
            act = {sf_out.id, sf_out.data, sf_out.resp, sf_out.last};
            cur = {sf_out.valid, act};
            if (sf_out.valid && sf_out.ready) begin
                if (q_sf.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL sf_unexpected_beat actual=%0h required=none", act);
                end else begin
                    exp = q_sf.pop_front();
                    checkOutput("sf_beat", act, exp);
                end
            end
            if (sf_hold) checkOutput("sf_stable_hold", cur, sf_prev);
            sf_hold = sf_out.valid & ~sf_out.ready;
            sf_prev = cur;

            checkOutput("sf_occ_bound", sf_occ <= 5'd16, 1'b1);
            checkOutput("sf_bursts_bound", sf_bursts <= sf_occ, 1'b1);
            checkOutput("sf_ready_rule", sf_in.ready, sf_occ != 5'd16);
            checkOutput("sf_valid_rule", sf_out.valid,
                        (sf_occ != 0) && ((sf_bursts != 0) || (sf_occ == 5'd16)));
            checkOutput("sf_af_rule", sf_af, sf_occ >= 5'd14);
            if (!sf_out.valid) checkOutput("sf_idle_payload", act, 0);

            act = {ct_out.id, ct_out.data, ct_out.resp, ct_out.last};
            if (ct_out.valid && ct_out.ready) begin
                if (q_ct.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL ct_unexpected_beat actual=%0h required=none", act);
                end else begin
                    exp = q_ct.pop_front();
                    checkOutput("ct_beat", act, exp);
                end
            end
            checkOutput("ct_occ_bound", ct_occ <= 3'd5, 1'b1);
            checkOutput("ct_ready_rule", ct_in.ready, ct_occ != 3'd5);
            checkOutput("ct_valid_rule", ct_out.valid, ct_occ != 3'd0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sf_in.valid = 1'b0; sf_in.id = '0; sf_in.data = '0; sf_in.resp = '0; sf_in.last = 1'b0;
        ct_in.valid = 1'b0; ct_in.id = '0; ct_in.data = '0; ct_in.resp = '0; ct_in.last = 1'b0;
        sf_out.ready = 1'b0;
        ct_out.ready = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_sf_occ", sf_occ, 0);
        checkOutput("rst_sf_bursts", sf_bursts, 0);
        checkOutput("rst_sf_err", sf_err, 0);
        checkOutput("rst_sf_valid", sf_out.valid, 0);
        checkOutput("rst_sf_ready", sf_in.ready, 1);
        checkOutput("rst_sf_af", sf_af, 0);
        checkOutput("rst_sf_data", sf_out.data, 0);
        checkOutput("rst_ct_occ", ct_occ, 0);
        checkOutput("rst_ct_ready", ct_in.ready, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Store-and-forward: 4-beat burst held until LAST is stored
        sf_out.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, mkBeat(4'd3, 64'(100 + i), 2'b00, i == 3));
            if (i < 3) checkOutput("sf_hold_valid", sf_out.valid, 0);
        end
        idleIn(1'b0);
        checkOutput("sf_release_valid", sf_out.valid, 1);
        checkOutput("sf_bursts_one", sf_bursts, 1);
        waitDrain(1'b0, "sf_burst4_drain");
        checkOutput("sf_bursts_zero", sf_bursts, 0);

        // 20-beat burst: full escape releases the head before LAST
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, mkBeat(4'd5, 64'(64'h2000 + i), 2'b00, i == 19));
            if (i == 15) begin
                checkOutput("sf_escape_occ", sf_occ, 16);
                checkOutput("sf_escape_ready", sf_in.ready, 0);
                checkOutput("sf_escape_valid", sf_out.valid, 1);
            end
        end
        idleIn(1'b0);
        waitDrain(1'b0, "sf_burst20_drain");

        // Cut-through, DEPTH=5: fill, then push and pop across pointer wrap
        for (int i = 0; i < 17; i++) begin
            if (i == 5) begin
                checkOutput("ct_full_ready", ct_in.ready, 0);
                checkOutput("ct_full_occ", ct_occ, 5);
                ct_out.ready = 1'b1;
            end
            applyStimulus(1'b1, mkBeat(4'd1, 64'(i), 2'b00, i == 16));
        end
        idleIn(1'b1);
        waitDrain(1'b1, "ct_drain");

        // almost_full threshold at 14
        sf_out.ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, mkBeat(4'd4, 64'(64'h300 + i), 2'b00, 1'b1));
            if (i == 12) begin
                checkOutput("af_at_13", sf_af, 0);
                checkOutput("occ_at_13", sf_occ, 13);
            end
        end
        idleIn(1'b0);
        checkOutput("af_at_14", sf_af, 1);
        sf_out.ready = 1'b1;
        @(posedge clk); #1;
        sf_out.ready = 1'b0;
        checkOutput("occ_after_pop", sf_occ, 13);
        checkOutput("af_after_pop", sf_af, 0);
        sf_out.ready = 1'b1;
        waitDrain(1'b0, "af_drain");

        // Saturating error counter (ERR_W=2)
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, mkBeat(4'd6, 64'(64'h400 + i), resp_seq[i], 1'b1));
            checkOutput($sformatf("err_cnt_%0d", i), sf_err, err_exp[i]);
        end
        idleIn(1'b0);
        waitDrain(1'b0, "err_drain");

        // Asynchronous reset mid-burst with 7 beats stored
        sf_out.ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, mkBeat(4'd7, 64'(64'h500 + i), 2'b00, (i == 2) || (i == 5)));
        end
        idleIn(1'b0);
        checkOutput("pre_rst_occ", sf_occ, 7);
        checkOutput("pre_rst_bursts", sf_bursts, 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_occ", sf_occ, 0);
        checkOutput("async_rst_bursts", sf_bursts, 0);
        checkOutput("async_rst_err", sf_err, 0);
        checkOutput("async_rst_valid", sf_out.valid, 0);
        checkOutput("async_rst_ready", sf_in.ready, 1);
        q_sf.delete();
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        sf_out.ready = 1'b1;
        applyStimulus(1'b0, mkBeat(4'd2, 64'hABCD, 2'b00, 1'b1));
        idleIn(1'b0);
        checkOutput("post_rst_valid", sf_out.valid, 1);
        waitDrain(1'b0, "post_rst_drain");
        checkOutput("post_rst_err", sf_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/r_burst_buffer.md
Name: r_burst_buffer

Overview:
Parametrised successor to the 8-entry R-beat FIFO. It sits between the AXI slave R channel and r_ordering_unit. Depth is configurable, and an optional store-and-forward mode holds beats back until a complete burst (LAST received) is stored. It also exports occupancy, almost-full and a saturating error-response counter.

Parameters:
ID_WIDTH, 4, R ID width
DATA_WIDTH, 64, R data width
RESP_WIDTH, 2, R resp width (must be >= 2)
DEPTH, 16, entries; any value >= 2, not required to be a power of 2
STORE_FWD, 1, 1 = release only complete bursts; 0 = cut-through
AF_THRESH, 14, almost_full asserts when occupancy >= AF_THRESH (1..DEPTH)
ERR_W, 8, error counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
r_in  r_if.receiver  id/data/resp/last/valid/ready  R beats from AXI slave
r_out  r_if.sender  id/data/resp/last/valid/ready  R beats to r_ordering_unit
occupancy  out  $clog2(DEPTH+1)  stored beats
almost_full  out  1  occupancy >= AF_THRESH
bursts_stored  out  $clog2(DEPTH+1)  stored beats with last=1
err_cnt  out  ERR_W  accepted beats with resp[1]=1 (SLVERR/DECERR), saturating

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: pointers, occupancy, bursts_stored and err_cnt are 0. r_out.valid=0, r_in.ready=1, almost_full=0, r_out payload=0. Memory contents are not reset.
- Reset asserted mid-operation discards all stored beats immediately (async). Valid and ready are deasserted or set to their reset values in the same instant.
- full = (occupancy == DEPTH). empty = (occupancy == 0).
- r_in.ready = ~full. It is combinational from state only, never from r_in.valid.
- push = r_in.valid & r_in.ready. pop = r_out.valid & r_out.ready.
- Release rule:
  - STORE_FWD=0: r_out.valid = ~empty.
  - STORE_FWD=1: r_out.valid = ~empty & ((bursts_stored != 0) | full).
  - The "| full" term is a deadlock escape for bursts longer than DEPTH. The head drains cut-through until the entry is no longer full.
- Payload: r_out id/data/resp/last = head entry when r_out.valid=1, otherwise all zero.
- Latency: a push is visible at the output the cycle after acceptance. No combinational path from r_in to r_out.
- Store-and-forward guarantee holds only for non-interleaved input. With interleaved IDs, release is triggered by any stored LAST beat.
- Pointers: wr_ptr and rd_ptr wrap from DEPTH-1 to 0 (explicit compare, non-power-of-2 safe).
- occupancy: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push and pop while full cannot occur, because ready=0.
  - Simultaneous push and pop while empty cannot occur, because valid=0.
- bursts_stored: +1 on push of a beat with last=1, -1 on pop of a beat with last=1, unchanged when both happen. It never exceeds occupancy.
- almost_full is registered-equivalent: it is computed from the occupancy register, not from next-state.
- err_cnt increments on push with r_in.resp[1]=1. It holds at all-ones (2^ERR_W-1) and never wraps. It clears only on reset.
- Stable-hold: while r_out.valid=1 and r_out.ready=0, the payload and valid are held stable (AXI rule).
- Assertions for the bench:
  - occupancy <= DEPTH.
  - bursts_stored <= occupancy.
  - No push when full.
  - No pop when empty.

Test Plan:
- STORE_FWD=1, DEPTH=16: push a 4-beat burst with id=3 (LAST on beat 4), r_out.ready=1 throughout -> r_out.valid stays 0 for beats 1-3. It asserts the cycle after beat 4 is accepted, then 4 beats drain in order. bursts_stored goes 1 then 0.
- STORE_FWD=1: push a 20-beat burst, r_out.ready=1 -> after 16 accepts full=1 and r_out.valid=1 (escape). All 20 beats exit in order, with no deadlock and no lost or duplicated beat.
- STORE_FWD=0, DEPTH=5 (non-power-of-2): fill 5 beats (data 0..4) with r_out.ready=0 -> r_in.ready=0 and occupancy=5. Then simultaneous push and pop for 12 cycles -> occupancy stays at the full level or below, and data order is preserved across pointer wrap.
- AF_THRESH=14: push 13 beats -> almost_full=0. Push the 14th beat -> almost_full=1 the next cycle. Pop one beat -> almost_full=0.
- ERR_W=2: push 5 beats with resp=2'b10 and 1 beat with resp=2'b11, interleaved with resp=2'b00 -> err_cnt sequence is 1, 2, 3, 3, 3, 3 (saturated at 3). resp=2'b01 beats do not count.
- Hold rst_n=0 asynchronously mid-burst with 7 beats stored -> occupancy, bursts_stored and err_cnt are 0 and r_out.valid=0 with no clock edge. After release, a new 1-beat burst passes through normally.
